// File: rtl/mult_seq_pkg.sv
// Shared widths, state codes and nibble-step shift lookup for the
// sequential 8x8 multiplier.
package mult_seq_pkg;

  localparam int NIB_W  = 4;
  localparam int OP_W   = 8;
  localparam int PROD_W = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_MUL   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Step order: aL*bL, aH*bL, aL*bH, aH*bH.
  function automatic logic [3:0] step_shift(input logic [1:0] step);
    case (step)
      2'd0:    return 4'd0;
      2'd1:    return 4'd4;
      2'd2:    return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [PROD_W-1:0] shift_pp(input logic [2*NIB_W-1:0] pp,
                                                 input logic [3:0] sh);
    return {{(PROD_W-2*NIB_W){1'b0}}, pp} << sh;
  endfunction

endpackage

// File: rtl/nib_mult_4x4.sv
// Combinational 4x4 unsigned array multiplier: sum of shifted AND rows.
module nib_mult_4x4
  import mult_seq_pkg::*;
(
  input  logic [NIB_W-1:0]   m,
  input  logic [NIB_W-1:0]   q,
  output logic [2*NIB_W-1:0] p
);

  always_comb begin
    p = '0;
    for (int i = 0; i < NIB_W; i++) begin
      if (q[i]) p = p + ({{NIB_W{1'b0}}, m} << i);
    end
  end

endmodule

// File: rtl/mult8_seq_ctrl.sv
// Sequencer producing an 8x8 product with one shared 4x4 nibble multiplier
// over four steps, with valid/ready handshakes on operands and result.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for operands, in_ready high
// ST_MUL   | one nibble partial product per cycle, step 0..3
// ST_FLUSH | PP_REG=1 only: fold in the last registered partial product
// ST_DONE  | product held, out_valid high until out_ready
module mult8_seq_ctrl
  import mult_seq_pkg::*;
#(
  parameter int PP_REG    = 0,
  parameter int ZERO_SKIP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] product,
  output logic              busy,
  output logic [1:0]        step
);

  logic [1:0]         state;
  logic [1:0]         step_q;
  logic [OP_W-1:0]    a_q;
  logic [OP_W-1:0]    b_q;
  logic [PROD_W-1:0]  acc;
  logic [2*NIB_W-1:0] pp_q;
  logic [3:0]         sh_q;
  logic [NIB_W-1:0]   nib_m;
  logic [NIB_W-1:0]   nib_q;
  logic [2*NIB_W-1:0] pp_w;
  logic [PROD_W-1:0]  add_term;
  logic [PROD_W-1:0]  acc_next;
  logic               accept;
  logic               zero_op;

  assign nib_m = step_q[0] ? a_q[7:4] : a_q[3:0];
  assign nib_q = step_q[1] ? b_q[7:4] : b_q[3:0];

  nib_mult_4x4 u_nib (
    .m (nib_m),
    .q (nib_q),
    .p (pp_w)
  );

  // With PP_REG the accumulator consumes the previous cycle's partial product.
  assign add_term = (PP_REG != 0) ? shift_pp(pp_q, sh_q)
                                  : shift_pp(pp_w, step_shift(step_q));
  assign acc_next = acc + add_term;

  assign in_ready = (state == ST_IDLE) && !rst;
  assign accept   = in_valid && in_ready;
  assign zero_op  = (ZERO_SKIP != 0) && ((a == '0) || (b == '0));
  assign busy     = (state != ST_IDLE);
  assign step     = (state == ST_MUL) ? step_q : 2'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      step_q    <= 2'd0;
      a_q       <= '0;
      b_q       <= '0;
      acc       <= '0;
      pp_q      <= '0;
      sh_q      <= '0;
      product   <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            a_q    <= a;
            b_q    <= b;
            acc    <= '0;
            step_q <= 2'd0;
            pp_q   <= '0;
            sh_q   <= '0;
            if (zero_op) begin
              product <= '0;
              state   <= ST_DONE;
            end else begin
              state <= ST_MUL;
            end
          end
        end
        ST_MUL: begin
          acc <= acc_next;
          if (PP_REG != 0) begin
            pp_q <= pp_w;
            sh_q <= step_shift(step_q);
          end
          if (step_q == 2'd3) begin
            step_q <= 2'd0;
            if (PP_REG != 0) begin
              state <= ST_FLUSH;
            end else begin
              product   <= acc_next;
              out_valid <= 1'b1;
              state     <= ST_DONE;
            end
          end else begin
            step_q <= step_q + 2'd1;
          end
        end
        ST_FLUSH: begin
          acc       <= acc_next;
          product   <= acc_next;
          out_valid <= 1'b1;
          state     <= ST_DONE;
        end
        default: begin
          // Zero-skip entry arrives here with out_valid still low.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// Bench for mult8_seq_ctrl: three configurations (PP_REG=0/ZS=1,
// PP_REG=1/ZS=1, PP_REG=0/ZS=0) checked against an arithmetic model.
module tb_mult8_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid_s  [3];
  logic [7:0]  a_s         [3];
  logic [7:0]  b_s         [3];
  logic        out_ready_s [3];
  logic        in_ready_w  [3];
  logic        out_valid_w [3];
  logic [15:0] product_w   [3];
  logic        busy_w      [3];
  logic [1:0]  step_w      [3];

  int checks = 0;
  int errors = 0;

  mult8_seq_ctrl #(.PP_REG(0), .ZERO_SKIP(1)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid_s[0]), .in_ready(in_ready_w[0]),
    .a(a_s[0]), .b(b_s[0]), .out_valid(out_valid_w[0]), .out_ready(out_ready_s[0]),
    .product(product_w[0]), .busy(busy_w[0]), .step(step_w[0]));

  mult8_seq_ctrl #(.PP_REG(1), .ZERO_SKIP(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_s[1]), .in_ready(in_ready_w[1]),
    .a(a_s[1]), .b(b_s[1]), .out_valid(out_valid_w[1]), .out_ready(out_ready_s[1]),
    .product(product_w[1]), .busy(busy_w[1]), .step(step_w[1]));

  mult8_seq_ctrl #(.PP_REG(0), .ZERO_SKIP(0)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid_s[2]), .in_ready(in_ready_w[2]),
    .a(a_s[2]), .b(b_s[2]), .out_valid(out_valid_w[2]), .out_ready(out_ready_s[2]),
    .product(product_w[2]), .busy(busy_w[2]), .step(step_w[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: configuration k -> (pp_reg, zero_skip)
  function automatic int cfg_pp(input int k);
    return (k == 1) ? 1 : 0;
  endfunction

  function automatic int cfg_zs(input int k);
    return (k == 2) ? 0 : 1;
  endfunction

  function automatic logic [15:0] ref_prod(input logic [7:0] av, input logic [7:0] bv);
    int r;
    r = int'(av) * int'(bv);
    return r[15:0];
  endfunction

  function automatic int ref_lat(input int k, input logic [7:0] av, input logic [7:0] bv);
    if (cfg_zs(k) != 0 && (av == 0 || bv == 0)) return 1;
    return (cfg_pp(k) != 0) ? 5 : 4;
  endfunction

  // Drives one transaction (caller is just past a rising edge) and reports
  // what it observed; comparisons are left to the calling test.
  task automatic run_txn(input int k, input logic [7:0] av, input logic [7:0] bv,
                         input int hold, input bit poke,
                         output int lat, output logic [15:0] prod,
                         output bit stable_ok, output logic ov_after,
                         output logic ir_after);
    int n;
    n = 0;
    lat = -1;
    prod = 16'hxxxx;
    stable_ok = 1'b1;
    ov_after = 1'bx;
    ir_after = 1'bx;
    while (in_ready_w[k] !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) return;
    in_valid_s[k] = 1'b1;
    a_s[k] = av;
    b_s[k] = bv;
    @(posedge clk); #1;
    in_valid_s[k] = 1'b0;
    a_s[k] = 8'($urandom);
    b_s[k] = 8'($urandom);
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (out_valid_w[k] !== 1'b1 && lat < 20);
    prod = product_w[k];
    repeat (hold) begin
      if (poke) begin
        in_valid_s[k] = 1'b1;
        a_s[k] = 8'h77;
        b_s[k] = 8'h33;
      end
      @(posedge clk); #1;
      if (out_valid_w[k] !== 1'b1 || product_w[k] !== prod || in_ready_w[k] !== 1'b0)
        stable_ok = 1'b0;
    end
    in_valid_s[k] = 1'b0;
    out_ready_s[k] = 1'b1;
    @(posedge clk); #1;
    out_ready_s[k] = 1'b0;
    ov_after = out_valid_w[k];
    ir_after = in_ready_w[k];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (out_valid_w[k] !== 1'b0 || busy_w[k] !== 1'b0 || product_w[k] !== 16'h0 ||
          step_w[k] !== 2'd0 || in_ready_w[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state dut%0d: ov=%b busy=%b prod=%h step=%0d ir=%b, required 0 0 0000 0 0",
                 k, out_valid_w[k], busy_w[k], product_w[k], step_w[k], in_ready_w[k]);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (in_ready_w[k] !== 1'b1) begin
        errors++;
        $display("FAIL reset_release_ready dut%0d: in_ready=%b, required 1", k, in_ready_w[k]);
      end
    end
  endtask

  task automatic test_full_scale();
    int lat; logic [15:0] prod; bit st; logic ov, ir;
    run_txn(0, 8'hFF, 8'hFF, 0, 1'b0, lat, prod, st, ov, ir);
    checks++;
    if (lat != 4 || prod !== 16'hFE01) begin
      errors++;
      $display("FAIL full_scale: lat=%0d prod=%h, required lat=4 prod=fe01", lat, prod);
    end
    checks++;
    if (ov !== 1'b0 || ir !== 1'b1) begin
      errors++;
      $display("FAIL full_scale_turnaround: out_valid=%b in_ready=%b, required 0 1", ov, ir);
    end
  endtask

  task automatic test_step_trace();
    logic [7:0] av, bv;
    logic [15:0] exp_acc;
    int pl, ph, sh;
    av = 8'h12;
    bv = 8'h34;
    exp_acc = 16'h0;
    in_valid_s[0] = 1'b1;
    a_s[0] = av;
    b_s[0] = bv;
    @(posedge clk); #1;
    in_valid_s[0] = 1'b0;
    a_s[0] = 8'hFF;
    b_s[0] = 8'hFF;
    for (int s = 0; s < 4; s++) begin
      checks++;
      if (step_w[0] !== s[1:0]) begin
        errors++;
        $display("FAIL step_trace s%0d: step=%0d, required %0d", s, step_w[0], s);
      end
      pl = (s % 2 == 1) ? int'(av[7:4]) : int'(av[3:0]);
      ph = (s / 2 == 1) ? int'(bv[7:4]) : int'(bv[3:0]);
      sh = 4 * ((s % 2) + (s / 2));
      exp_acc = exp_acc + 16'((pl * ph) << sh);
      @(posedge clk); #1;
      checks++;
      if (u_dut0.acc !== exp_acc) begin
        errors++;
        $display("FAIL acc_trace s%0d: acc=%h, required %h", s, u_dut0.acc, exp_acc);
      end
    end
    checks++;
    if (out_valid_w[0] !== 1'b1 || product_w[0] !== 16'h03A8 || step_w[0] !== 2'd0) begin
      errors++;
      $display("FAIL step_trace_result: ov=%b prod=%h step=%0d, required 1 03a8 0",
               out_valid_w[0], product_w[0], step_w[0]);
    end
    out_ready_s[0] = 1'b1;
    @(posedge clk); #1;
    out_ready_s[0] = 1'b0;
  endtask

  task automatic test_backpressure();
    int lat; logic [15:0] prod; bit st; logic ov, ir;
    run_txn(0, 8'h0F, 8'h10, 6, 1'b1, lat, prod, st, ov, ir);
    checks++;
    if (lat != 4 || prod !== 16'h00F0) begin
      errors++;
      $display("FAIL backpressure_result: lat=%0d prod=%h, required lat=4 prod=00f0", lat, prod);
    end
    checks++;
    if (st !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_hold: stable=%b, required 1", st);
    end
    checks++;
    if (ov !== 1'b0 || ir !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release: out_valid=%b in_ready=%b, required 0 1", ov, ir);
    end
    @(posedge clk); #1;
    checks++;
    if (busy_w[0] !== 1'b0 || product_w[0] !== 16'h00F0) begin
      errors++;
      $display("FAIL backpressure_ignored_input: busy=%b prod=%h, required 0 00f0",
               busy_w[0], product_w[0]);
    end
  endtask

  task automatic test_zero_skip();
    int lat; logic [15:0] prod; bit st; logic ov, ir;
    run_txn(0, 8'h00, 8'h5A, 0, 1'b0, lat, prod, st, ov, ir);
    checks++;
    if (lat != 1 || prod !== 16'h0000) begin
      errors++;
      $display("FAIL zero_skip_a: lat=%0d prod=%h, required lat=1 prod=0000", lat, prod);
    end
    run_txn(0, 8'h5A, 8'h00, 0, 1'b0, lat, prod, st, ov, ir);
    checks++;
    if (lat != 1 || prod !== 16'h0000) begin
      errors++;
      $display("FAIL zero_skip_b: lat=%0d prod=%h, required lat=1 prod=0000", lat, prod);
    end
    run_txn(2, 8'h00, 8'h5A, 0, 1'b0, lat, prod, st, ov, ir);
    checks++;
    if (lat != 4 || prod !== 16'h0000) begin
      errors++;
      $display("FAIL no_zero_skip: lat=%0d prod=%h, required lat=4 prod=0000", lat, prod);
    end
  endtask

  task automatic test_pp_reg();
    int lat; logic [15:0] prod; bit st; logic ov, ir;
    run_txn(1, 8'hAB, 8'hCD, 2, 1'b0, lat, prod, st, ov, ir);
    checks++;
    if (lat != 5 || prod !== 16'h88EF) begin
      errors++;
      $display("FAIL pp_reg_latency: lat=%0d prod=%h, required lat=5 prod=88ef", lat, prod);
    end
    checks++;
    if (st !== 1'b1 || ov !== 1'b0 || ir !== 1'b1) begin
      errors++;
      $display("FAIL pp_reg_handshake: stable=%b out_valid=%b in_ready=%b, required 1 0 1",
               st, ov, ir);
    end
  endtask

  task automatic test_reset_midop();
    int n; int lat; logic [15:0] prod; bit st; logic ov, ir;
    in_valid_s[0] = 1'b1;
    a_s[0] = 8'hAB;
    b_s[0] = 8'hCD;
    @(posedge clk); #1;
    in_valid_s[0] = 1'b0;
    n = 0;
    while (step_w[0] !== 2'd2 && n < 10) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (step_w[0] !== 2'd2) begin
      errors++;
      $display("FAIL midop_reach_step2: step=%0d, required 2", step_w[0]);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid_w[0] !== 1'b0 || busy_w[0] !== 1'b0 || product_w[0] !== 16'h0 ||
        step_w[0] !== 2'd0 || u_dut0.acc !== 16'h0) begin
      errors++;
      $display("FAIL midop_async_reset: ov=%b busy=%b prod=%h step=%0d acc=%h, required 0 0 0000 0 0000",
               out_valid_w[0], busy_w[0], product_w[0], step_w[0], u_dut0.acc);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_txn(0, 8'h03, 8'h05, 0, 1'b0, lat, prod, st, ov, ir);
    checks++;
    if (lat != 4 || prod !== 16'h000F) begin
      errors++;
      $display("FAIL midop_after_reset: lat=%0d prod=%h, required lat=4 prod=000f", lat, prod);
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic [15:0] prod; bit st; logic ov, ir;
    logic [7:0] av, bv;
    int hold;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 25; i++) begin
        av = 8'($urandom);
        bv = 8'($urandom);
        if ($urandom_range(0, 7) == 0) av = 8'h00;
        if ($urandom_range(0, 7) == 0) bv = 8'h00;
        hold = $urandom_range(0, 2);
        run_txn(k, av, bv, hold, 1'b0, lat, prod, st, ov, ir);
        checks++;
        if (lat != ref_lat(k, av, bv) || prod !== ref_prod(av, bv) || st !== 1'b1 ||
            ov !== 1'b0 || ir !== 1'b1) begin
          errors++;
          $display("FAIL b2b dut%0d %h*%h: lat=%0d prod=%h stable=%b ov=%b ir=%b, required lat=%0d prod=%h 1 0 1",
                   k, av, bv, lat, prod, st, ov, ir, ref_lat(k, av, bv), ref_prod(av, bv));
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid_s[k]  = 1'b0;
      a_s[k]         = 8'h00;
      b_s[k]         = 8'h00;
      out_ready_s[k] = 1'b0;
    end
    test_reset();
    test_full_scale();
    test_step_trace();
    test_backpressure();
    test_zero_skip();
    test_pp_reg();
    test_reset_midop();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
